// File: rtl/fp_execute_stage2.sv
// Stage 2 of the FP/integer multiply pipeline: significand alignment with G/R/S extraction and the 32x32 product.
// Optional macro FX2_MUL_UNDERFLOW_FLUSH_EN flushes underflowing fmul products and exponents to zero.
package fp_defines;
    localparam int NUM_VECTOR_LANES = 16;

    typedef logic [1:0] local_thread_idx_t;
    typedef logic [3:0] subcycle_t;
    typedef logic [NUM_VECTOR_LANES-1:0] vector_mask_t;

    typedef enum logic [5:0] {
        OP_OR     = 6'h00,
        OP_AND    = 6'h01,
        OP_XOR    = 6'h03,
        OP_ADD_I  = 6'h05,
        OP_SUB_I  = 6'h06,
        OP_MULL_I = 6'h07,
        OP_MULH_U = 6'h08,
        OP_MULH_I = 6'h1f,
        OP_ADD_F  = 6'h20,
        OP_SUB_F  = 6'h21,
        OP_MUL_F  = 6'h22,
        OP_ITOF   = 6'h2a,
        OP_FTOI   = 6'h1b
    } alu_op_t;

    typedef struct packed {
        logic [31:0] pc;
        alu_op_t     alu_op;
        logic [4:0]  dest_reg;
        logic        has_dest;
        logic        dest_vector;
    } decoded_instruction_t;
endpackage

module fp_execute_stage2
    import fp_defines::*;
(
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   wb_rollback_en,
    input  local_thread_idx_t                      wb_rollback_thread_idx,
    input  logic                                   fx1_instruction_valid,
    input  decoded_instruction_t                   fx1_instruction,
    input  vector_mask_t                           fx1_mask_value,
    input  local_thread_idx_t                      fx1_thread_idx,
    input  subcycle_t                              fx1_subcycle,
    input  logic [NUM_VECTOR_LANES-1:0]            fx1_result_inf,
    input  logic [NUM_VECTOR_LANES-1:0]            fx1_result_nan,
    input  logic [NUM_VECTOR_LANES-1:0]            fx1_equal,
    input  logic [NUM_VECTOR_LANES-1:0]            fx1_logical_subtract,
    input  logic [NUM_VECTOR_LANES-1:0]            fx1_add_result_sign,
    input  logic [NUM_VECTOR_LANES-1:0]            fx1_mul_underflow,
    input  logic [NUM_VECTOR_LANES-1:0]            fx1_mul_sign,
    input  logic [NUM_VECTOR_LANES-1:0][5:0]       fx1_ftoi_lshift,
    input  logic [NUM_VECTOR_LANES-1:0][5:0]       fx1_se_align_shift,
    input  logic [NUM_VECTOR_LANES-1:0][31:0]      fx1_significand_le,
    input  logic [NUM_VECTOR_LANES-1:0][31:0]      fx1_significand_se,
    input  logic [NUM_VECTOR_LANES-1:0][31:0]      fx1_multiplicand,
    input  logic [NUM_VECTOR_LANES-1:0][31:0]      fx1_multiplier,
    input  logic [NUM_VECTOR_LANES-1:0][7:0]       fx1_add_exponent,
    input  logic [NUM_VECTOR_LANES-1:0][7:0]       fx1_mul_exponent,
    output logic                                   fx2_instruction_valid,
    output decoded_instruction_t                   fx2_instruction,
    output vector_mask_t                           fx2_mask_value,
    output local_thread_idx_t                      fx2_thread_idx,
    output subcycle_t                              fx2_subcycle,
    output logic [NUM_VECTOR_LANES-1:0]            fx2_result_inf,
    output logic [NUM_VECTOR_LANES-1:0]            fx2_result_nan,
    output logic [NUM_VECTOR_LANES-1:0]            fx2_equal,
    output logic [NUM_VECTOR_LANES-1:0]            fx2_logical_subtract,
    output logic [NUM_VECTOR_LANES-1:0]            fx2_add_result_sign,
    output logic [NUM_VECTOR_LANES-1:0]            fx2_mul_underflow,
    output logic [NUM_VECTOR_LANES-1:0]            fx2_mul_sign,
    output logic [NUM_VECTOR_LANES-1:0][5:0]       fx2_ftoi_lshift,
    output logic [NUM_VECTOR_LANES-1:0][7:0]       fx2_add_exponent,
    output logic [NUM_VECTOR_LANES-1:0][7:0]       fx2_mul_exponent,
    output logic [NUM_VECTOR_LANES-1:0][31:0]      fx2_significand_le,
    output logic [NUM_VECTOR_LANES-1:0][31:0]      fx2_significand_se,
    output logic [NUM_VECTOR_LANES-1:0]            fx2_guard,
    output logic [NUM_VECTOR_LANES-1:0]            fx2_round,
    output logic [NUM_VECTOR_LANES-1:0]            fx2_sticky,
    output logic [NUM_VECTOR_LANES-1:0][63:0]      fx2_significand_product
);
    typedef struct packed {
        logic                              valid;
        decoded_instruction_t              instruction;
        vector_mask_t                      mask_value;
        local_thread_idx_t                 thread_idx;
        subcycle_t                         subcycle;
        logic [NUM_VECTOR_LANES-1:0]       result_inf;
        logic [NUM_VECTOR_LANES-1:0]       result_nan;
        logic [NUM_VECTOR_LANES-1:0]       equal;
        logic [NUM_VECTOR_LANES-1:0]       logical_subtract;
        logic [NUM_VECTOR_LANES-1:0]       add_result_sign;
        logic [NUM_VECTOR_LANES-1:0]       mul_underflow;
        logic [NUM_VECTOR_LANES-1:0]       mul_sign;
        logic [NUM_VECTOR_LANES-1:0][5:0]  ftoi_lshift;
        logic [NUM_VECTOR_LANES-1:0][7:0]  add_exponent;
        logic [NUM_VECTOR_LANES-1:0][7:0]  mul_exponent;
        logic [NUM_VECTOR_LANES-1:0][31:0] significand_le;
        logic [NUM_VECTOR_LANES-1:0][31:0] significand_se;
        logic [NUM_VECTOR_LANES-1:0]       guard;
        logic [NUM_VECTOR_LANES-1:0]       round;
        logic [NUM_VECTOR_LANES-1:0]       sticky;
        logic [NUM_VECTOR_LANES-1:0][63:0] product;
    } stage_regs_t;

    stage_regs_t stage_d;
    stage_regs_t stage_q;

    logic        signed_mul;
    logic        is_fmul;
    logic [95:0] align_tmp;
    logic [63:0] mul_a;
    logic [63:0] mul_b;

    assign signed_mul = (fx1_instruction.alu_op == OP_MULH_I);
    assign is_fmul    = (fx1_instruction.alu_op == OP_MUL_F);

    always_comb begin
        stage_d                  = '0;
        align_tmp                = '0;
        mul_a                    = '0;
        mul_b                    = '0;
        stage_d.valid            = fx1_instruction_valid
                                   && !(wb_rollback_en && wb_rollback_thread_idx == fx1_thread_idx);
        stage_d.instruction      = fx1_instruction;
        stage_d.mask_value       = fx1_mask_value;
        stage_d.thread_idx       = fx1_thread_idx;
        stage_d.subcycle         = fx1_subcycle;
        stage_d.result_inf       = fx1_result_inf;
        stage_d.result_nan       = fx1_result_nan;
        stage_d.equal            = fx1_equal;
        stage_d.logical_subtract = fx1_logical_subtract;
        stage_d.add_result_sign  = fx1_add_result_sign;
        stage_d.mul_underflow    = fx1_mul_underflow;
        stage_d.mul_sign         = fx1_mul_sign;
        stage_d.ftoi_lshift      = fx1_ftoi_lshift;
        stage_d.add_exponent     = fx1_add_exponent;
        stage_d.significand_le   = fx1_significand_le;
        for (int lane = 0; lane < NUM_VECTOR_LANES; lane++) begin
            // 64 zero bits below the significand keep every shifted-out bit (s up to 63) for G/R/S.
            align_tmp = {fx1_significand_se[lane], 64'd0} >> fx1_se_align_shift[lane];
            stage_d.significand_se[lane] = align_tmp[95:64];
            stage_d.guard[lane]          = align_tmp[63];
            stage_d.round[lane]          = align_tmp[62];
            stage_d.sticky[lane]         = |align_tmp[61:0];

            // Low 64 bits of a sign/zero-extended product equal the exact 32x32 result.
            mul_a = signed_mul ? {{32{fx1_multiplicand[lane][31]}}, fx1_multiplicand[lane]}
                               : {32'd0, fx1_multiplicand[lane]};
            mul_b = signed_mul ? {{32{fx1_multiplier[lane][31]}}, fx1_multiplier[lane]}
                               : {32'd0, fx1_multiplier[lane]};
            stage_d.product[lane]      = mul_a * mul_b;
            stage_d.mul_exponent[lane] = fx1_mul_exponent[lane];
`ifdef FX2_MUL_UNDERFLOW_FLUSH_EN
            if (is_fmul && fx1_mul_underflow[lane]) begin
                stage_d.product[lane]      = 64'd0;
                stage_d.mul_exponent[lane] = 8'd0;
            end
`else
            stage_d.product[lane] = is_fmul ? stage_d.product[lane] : stage_d.product[lane];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            stage_q <= '0;
        else
            stage_q <= stage_d;
    end

    assign fx2_instruction_valid   = stage_q.valid;
    assign fx2_instruction         = stage_q.instruction;
    assign fx2_mask_value          = stage_q.mask_value;
    assign fx2_thread_idx          = stage_q.thread_idx;
    assign fx2_subcycle            = stage_q.subcycle;
    assign fx2_result_inf          = stage_q.result_inf;
    assign fx2_result_nan          = stage_q.result_nan;
    assign fx2_equal               = stage_q.equal;
    assign fx2_logical_subtract    = stage_q.logical_subtract;
    assign fx2_add_result_sign     = stage_q.add_result_sign;
    assign fx2_mul_underflow       = stage_q.mul_underflow;
    assign fx2_mul_sign            = stage_q.mul_sign;
    assign fx2_ftoi_lshift         = stage_q.ftoi_lshift;
    assign fx2_add_exponent        = stage_q.add_exponent;
    assign fx2_mul_exponent        = stage_q.mul_exponent;
    assign fx2_significand_le      = stage_q.significand_le;
    assign fx2_significand_se      = stage_q.significand_se;
    assign fx2_guard               = stage_q.guard;
    assign fx2_round               = stage_q.round;
    assign fx2_sticky              = stage_q.sticky;
    assign fx2_significand_product = stage_q.product;
endmodule

// File: tb/tb_fp_execute_stage2.sv
// Directed bench for fp_execute_stage2: reset, alignment/G-R-S, integer and float products, rollback squash.
module tb_fp_execute_stage2;
    import fp_defines::*;

    localparam int N = NUM_VECTOR_LANES;
    localparam int INSTR_W = $bits(decoded_instruction_t);

    logic clk = 1'b0;
    logic reset;
    logic wb_rollback_en;
    local_thread_idx_t wb_rollback_thread_idx;
    logic fx1_instruction_valid;
    decoded_instruction_t fx1_instruction;
    vector_mask_t fx1_mask_value;
    local_thread_idx_t fx1_thread_idx;
    subcycle_t fx1_subcycle;
    logic [N-1:0] fx1_result_inf, fx1_result_nan, fx1_equal, fx1_logical_subtract;
    logic [N-1:0] fx1_add_result_sign, fx1_mul_underflow, fx1_mul_sign;
    logic [N-1:0][5:0] fx1_ftoi_lshift, fx1_se_align_shift;
    logic [N-1:0][31:0] fx1_significand_le, fx1_significand_se, fx1_multiplicand, fx1_multiplier;
    logic [N-1:0][7:0] fx1_add_exponent, fx1_mul_exponent;

    logic fx2_instruction_valid;
    decoded_instruction_t fx2_instruction;
    vector_mask_t fx2_mask_value;
    local_thread_idx_t fx2_thread_idx;
    subcycle_t fx2_subcycle;
    logic [N-1:0] fx2_result_inf, fx2_result_nan, fx2_equal, fx2_logical_subtract;
    logic [N-1:0] fx2_add_result_sign, fx2_mul_underflow, fx2_mul_sign;
    logic [N-1:0][5:0] fx2_ftoi_lshift;
    logic [N-1:0][7:0] fx2_add_exponent, fx2_mul_exponent;
    logic [N-1:0][31:0] fx2_significand_le, fx2_significand_se;
    logic [N-1:0] fx2_guard, fx2_round, fx2_sticky;
    logic [N-1:0][63:0] fx2_significand_product;

    int vec_count = 0;
    int err_count = 0;

    fp_execute_stage2 dut (
        .clk(clk), .reset(reset),
        .wb_rollback_en(wb_rollback_en), .wb_rollback_thread_idx(wb_rollback_thread_idx),
        .fx1_instruction_valid(fx1_instruction_valid), .fx1_instruction(fx1_instruction),
        .fx1_mask_value(fx1_mask_value), .fx1_thread_idx(fx1_thread_idx), .fx1_subcycle(fx1_subcycle),
        .fx1_result_inf(fx1_result_inf), .fx1_result_nan(fx1_result_nan), .fx1_equal(fx1_equal),
        .fx1_logical_subtract(fx1_logical_subtract), .fx1_add_result_sign(fx1_add_result_sign),
        .fx1_mul_underflow(fx1_mul_underflow), .fx1_mul_sign(fx1_mul_sign),
        .fx1_ftoi_lshift(fx1_ftoi_lshift), .fx1_se_align_shift(fx1_se_align_shift),
        .fx1_significand_le(fx1_significand_le), .fx1_significand_se(fx1_significand_se),
        .fx1_multiplicand(fx1_multiplicand), .fx1_multiplier(fx1_multiplier),
        .fx1_add_exponent(fx1_add_exponent), .fx1_mul_exponent(fx1_mul_exponent),
        .fx2_instruction_valid(fx2_instruction_valid), .fx2_instruction(fx2_instruction),
        .fx2_mask_value(fx2_mask_value), .fx2_thread_idx(fx2_thread_idx), .fx2_subcycle(fx2_subcycle),
        .fx2_result_inf(fx2_result_inf), .fx2_result_nan(fx2_result_nan), .fx2_equal(fx2_equal),
        .fx2_logical_subtract(fx2_logical_subtract), .fx2_add_result_sign(fx2_add_result_sign),
        .fx2_mul_underflow(fx2_mul_underflow), .fx2_mul_sign(fx2_mul_sign),
        .fx2_ftoi_lshift(fx2_ftoi_lshift), .fx2_add_exponent(fx2_add_exponent),
        .fx2_mul_exponent(fx2_mul_exponent), .fx2_significand_le(fx2_significand_le),
        .fx2_significand_se(fx2_significand_se), .fx2_guard(fx2_guard), .fx2_round(fx2_round),
        .fx2_sticky(fx2_sticky), .fx2_significand_product(fx2_significand_product)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_count++;
        if (obs !== exp) begin
            err_count++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wb_rollback_en = 1'b0;
        wb_rollback_thread_idx = '0;
        fx1_instruction_valid = 1'b0;
        fx1_instruction = '0;
        fx1_mask_value = '0;
        fx1_thread_idx = '0;
        fx1_subcycle = '0;
        fx1_result_inf = '0; fx1_result_nan = '0; fx1_equal = '0; fx1_logical_subtract = '0;
        fx1_add_result_sign = '0; fx1_mul_underflow = '0; fx1_mul_sign = '0;
        fx1_ftoi_lshift = '0; fx1_se_align_shift = '0;
        fx1_significand_le = '0; fx1_significand_se = '0;
        fx1_multiplicand = '0; fx1_multiplier = '0;
        fx1_add_exponent = '0; fx1_mul_exponent = '0;
    endtask

    task automatic set_mul(input alu_op_t op);
        clear_inputs();
        fx1_instruction_valid = 1'b1;
        fx1_instruction.alu_op = op;
        fx1_multiplicand[0] = 32'hFFFFFFFF; fx1_multiplier[0] = 32'h00000002;
        fx1_multiplicand[1] = 32'hFFFFFFFF; fx1_multiplier[1] = 32'hFFFFFFFF;
        fx1_multiplicand[2] = 32'h80000000; fx1_multiplier[2] = 32'h80000000;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        // Valid, non-zero inputs present while reset is held.
        set_mul(OP_MULH_I);
        fx1_significand_se[0] = 32'h00C00001;
        fx1_significand_le[0] = 32'h12345678;
        fx1_mul_exponent[0] = 8'h7F;
        fx1_mask_value = 16'hFFFF;
        fx1_mul_sign = '1;
        tick();
        tick();
        check_val("rst_valid", 64'(fx2_instruction_valid), 64'd0);
        check_val("rst_instr", {{(64-INSTR_W){1'b0}}, fx2_instruction}, 64'd0);
        check_val("rst_mask", 64'(fx2_mask_value), 64'd0);
        check_val("rst_prod", 64'(|fx2_significand_product), 64'd0);
        check_val("rst_se", 64'(|fx2_significand_se), 64'd0);
        check_val("rst_le", 64'(|fx2_significand_le), 64'd0);
        check_val("rst_mexp", 64'(|fx2_mul_exponent), 64'd0);
        check_val("rst_flags", 64'(|{fx2_mul_sign, fx2_guard, fx2_round, fx2_sticky}), 64'd0);
        reset = 1'b0;

        // Alignment plus sideband/flag pass-through.
        clear_inputs();
        fx1_instruction_valid = 1'b1;
        fx1_instruction.alu_op = OP_ADD_F;
        fx1_instruction.pc = 32'h00001040;
        fx1_mask_value = 16'hA5A5;
        fx1_thread_idx = 2'd3;
        fx1_subcycle = 4'd3;
        fx1_result_inf = 16'h0001; fx1_result_nan = 16'h0002; fx1_equal = 16'h0004;
        fx1_logical_subtract = 16'h0008; fx1_add_result_sign = 16'h0010; fx1_mul_sign = 16'h0020;
        fx1_ftoi_lshift[5] = 6'd17;
        fx1_add_exponent[3] = 8'h83;
        fx1_significand_le[7] = 32'hDEADBEEF;
        for (int i = 0; i < N; i++) fx1_significand_se[i] = 32'h00C00001;
        fx1_se_align_shift[0] = 6'd3;
        fx1_se_align_shift[1] = 6'd0;
        fx1_se_align_shift[2] = 6'd32;
        fx1_se_align_shift[3] = 6'd1;
        fx1_se_align_shift[4] = 6'd2;
        tick();
        check_val("al_valid", 64'(fx2_instruction_valid), 64'd1);
        check_val("al_pc", 64'(fx2_instruction.pc), 64'h1040);
        check_val("al_mask", 64'(fx2_mask_value), 64'hA5A5);
        check_val("al_thread", 64'(fx2_thread_idx), 64'd3);
        check_val("al_subcycle", 64'(fx2_subcycle), 64'd3);
        check_val("al_flags", 64'({fx2_mul_sign[5], fx2_add_result_sign[4], fx2_logical_subtract[3],
                                    fx2_equal[2], fx2_result_nan[1], fx2_result_inf[0]}), 64'h3F);
        check_val("al_flags_or", 64'(|(fx2_result_inf | fx2_result_nan | fx2_equal)), 64'd1);
        check_val("al_ftoi", 64'(fx2_ftoi_lshift[5]), 64'd17);
        check_val("al_aexp", 64'(fx2_add_exponent[3]), 64'h83);
        check_val("al_le", 64'(fx2_significand_le[7]), 64'hDEADBEEF);
        check_val("al_s3_se", 64'(fx2_significand_se[0]), 64'h00180000);
        check_val("al_s3_grs", 64'({fx2_guard[0], fx2_round[0], fx2_sticky[0]}), 64'b001);
        check_val("al_s0_se", 64'(fx2_significand_se[1]), 64'h00C00001);
        check_val("al_s0_grs", 64'({fx2_guard[1], fx2_round[1], fx2_sticky[1]}), 64'b000);
        check_val("al_s32_se", 64'(fx2_significand_se[2]), 64'h0);
        check_val("al_s32_grs", 64'({fx2_guard[2], fx2_round[2], fx2_sticky[2]}), 64'b001);
        check_val("al_s1_se", 64'(fx2_significand_se[3]), 64'h00600000);
        check_val("al_s1_grs", 64'({fx2_guard[3], fx2_round[3], fx2_sticky[3]}), 64'b100);
        check_val("al_s2_se", 64'(fx2_significand_se[4]), 64'h00300000);
        check_val("al_s2_grs", 64'({fx2_guard[4], fx2_round[4], fx2_sticky[4]}), 64'b010);

        set_mul(OP_MULH_I);
        tick();
        check_val("mulh_i_l0", fx2_significand_product[0], 64'hFFFFFFFFFFFFFFFE);
        check_val("mulh_i_l1", fx2_significand_product[1], 64'h0000000000000001);
        check_val("mulh_i_l2", fx2_significand_product[2], 64'h4000000000000000);

        // Underflow flag on an integer multiply must never flush.
        set_mul(OP_MULH_U);
        fx1_mul_underflow = '1;
        fx1_mul_exponent[0] = 8'h44;
        tick();
        check_val("mulh_u_l0", fx2_significand_product[0], 64'h00000001FFFFFFFE);
        check_val("mulh_u_l1", fx2_significand_product[1], 64'hFFFFFFFE00000001);
        check_val("mulh_u_l2", fx2_significand_product[2], 64'h4000000000000000);
        check_val("mulh_u_exp", 64'(fx2_mul_exponent[0]), 64'h44);
        check_val("mulh_u_uf", 64'(fx2_mul_underflow), 64'hFFFF);

        set_mul(OP_MULL_I);
        tick();
        check_val("mull_i_l0", fx2_significand_product[0], 64'h00000001FFFFFFFE);

        clear_inputs();
        fx1_instruction_valid = 1'b1;
        fx1_instruction.alu_op = OP_MUL_F;
        fx1_multiplicand[0] = 32'h00800000; fx1_multiplier[0] = 32'h00800000;
        fx1_mul_exponent[0] = 8'h7F; fx1_mul_sign[0] = 1'b1;
        fx1_multiplicand[1] = 32'h00800000; fx1_multiplier[1] = 32'h00800000;
        fx1_mul_exponent[1] = 8'h05; fx1_mul_underflow[1] = 1'b1; fx1_mul_sign[1] = 1'b1;
        tick();
        check_val("fmul_prod", fx2_significand_product[0], 64'h0000400000000000);
        check_val("fmul_exp", 64'(fx2_mul_exponent[0]), 64'h7F);
        check_val("fmul_sign", 64'(fx2_mul_sign[1:0]), 64'b11);
        check_val("fmul_uf_flag", 64'(fx2_mul_underflow[1]), 64'd1);
`ifdef FX2_MUL_UNDERFLOW_FLUSH_EN
        check_val("fmul_uf_prod", fx2_significand_product[1], 64'h0);
        check_val("fmul_uf_exp", 64'(fx2_mul_exponent[1]), 64'h0);
`else
        check_val("fmul_uf_prod", fx2_significand_product[1], 64'h0000400000000000);
        check_val("fmul_uf_exp", 64'(fx2_mul_exponent[1]), 64'h05);
`endif

        // Rollback of the same thread squashes valid but data still loads.
        clear_inputs();
        fx1_instruction_valid = 1'b1;
        fx1_thread_idx = 2'd2;
        fx1_significand_le[0] = 32'hCAFEF00D;
        wb_rollback_en = 1'b1;
        wb_rollback_thread_idx = 2'd2;
        tick();
        check_val("rb_same_valid", 64'(fx2_instruction_valid), 64'd0);
        check_val("rb_same_le", 64'(fx2_significand_le[0]), 64'hCAFEF00D);

        wb_rollback_thread_idx = 2'd1;
        tick();
        check_val("rb_other_valid", 64'(fx2_instruction_valid), 64'd1);

        clear_inputs();
        tick();
        check_val("idle_valid", 64'(fx2_instruction_valid), 64'd0);

        // Reset in the middle of a stream drops the in-flight instruction.
        set_mul(OP_MULH_U);
        reset = 1'b1;
        tick();
        check_val("mid_rst_valid", 64'(fx2_instruction_valid), 64'd0);
        check_val("mid_rst_prod", fx2_significand_product[0], 64'h0);
        reset = 1'b0;
        tick();
        check_val("post_rst_valid", 64'(fx2_instruction_valid), 64'd1);
        check_val("post_rst_prod", fx2_significand_product[0], 64'h00000001FFFFFFFE);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end
endmodule

// File: doc/fp_execute_stage2.md
# fp_execute_stage2

Second stage of the floating point/integer multiply pipeline, directly downstream of fp_execute_stage1. Per lane it right-aligns the smaller-exponent significand by the stage-1 shift count, extracting guard/round/sticky bits. It also forms the full 64-bit significand/integer product and passes exception flags and exponents through to fp_execute_stage3. Single-cycle registered stage that squashes instructions belonging to a rolled-back thread.

## Interface
- Parameters: none; lane count is NUM_VECTOR_LANES from defines.
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- wb_rollback_en  in  1  rollback request from writeback_stage
- wb_rollback_thread_idx  in  local_thread_idx_t  thread being rolled back
- fx1_instruction_valid, fx1_instruction, fx1_mask_value, fx1_thread_idx, fx1_subcycle  in  (stage-1 types)  instruction sideband
- fx1_result_inf, fx1_result_nan, fx1_equal, fx1_logical_subtract, fx1_add_result_sign, fx1_mul_underflow, fx1_mul_sign  in  NUM_VECTOR_LANES  per-lane flags
- fx1_ftoi_lshift, fx1_se_align_shift  in  NUM_VECTOR_LANES x 6  per-lane shift counts
- fx1_significand_le, fx1_significand_se, fx1_multiplicand, fx1_multiplier  in  NUM_VECTOR_LANES x 32  per-lane operands
- fx1_add_exponent, fx1_mul_exponent  in  NUM_VECTOR_LANES x 8  per-lane exponents
- fx2_instruction_valid, fx2_instruction, fx2_mask_value, fx2_thread_idx, fx2_subcycle  out  sideband, registered
- fx2_result_inf, fx2_result_nan, fx2_equal, fx2_logical_subtract, fx2_add_result_sign, fx2_mul_underflow, fx2_mul_sign, fx2_ftoi_lshift, fx2_add_exponent, fx2_mul_exponent, fx2_significand_le  out  registered pass-through
- fx2_significand_se  out  NUM_VECTOR_LANES x 32  aligned smaller significand
- fx2_guard, fx2_round, fx2_sticky  out  NUM_VECTOR_LANES  bits shifted out
- fx2_significand_product  out  NUM_VECTOR_LANES x 64  product

## Operation
- Alignment, per lane, s = fx1_se_align_shift (0..32): fx2_significand_se = fx1_significand_se >> s; s >= 32 gives 0.
- guard = bit s-1 of the input; round = bit s-2; sticky = OR of bits [s-3:0]. Bits with negative index read as 0, so s=0 gives all three 0 and s=1 gives guard only.
- Alignment is applied identically for add/sub/compare, ftoi truncation and itof (s=0).
- Multiply: OP_MULH_I is signed 32x32 -> 64. OP_MULL_I, OP_MULH_U and OP_MUL_F are unsigned 32x32 -> 64; fmul operands are zero-extended 24-bit significands.
- All other fields are copied unchanged.
- fx2_instruction_valid <= fx1_instruction_valid && !(wb_rollback_en && wb_rollback_thread_idx == fx1_thread_idx).
- A rollback for a different thread does not affect the stage.
- Data registers load every cycle regardless of valid; downstream qualifies them with fx2_instruction_valid.

## Timing
- Latency 1 cycle, no stalls, no backpressure; one instruction (one subcycle) accepted per cycle.
- Reset (synchronous): every output register, valid and data, is 0 on the cycle after reset is sampled high.
- Reset asserted mid-stream: the in-flight instruction is dropped, with valid 0 the following cycle.
- Rollback and a valid input for the same thread in the same cycle: the output is invalid next cycle.
- Rollback has no effect on data registers.

## Configuration
- FX2_MUL_UNDERFLOW_FLUSH_EN defined: for OP_MUL_F lanes with fx1_mul_underflow=1, fx2_significand_product is forced to 0 and fx2_mul_exponent to 0, flushing underflowing products to signed zero.
- Not defined: product and exponent pass through unmodified; fx2_mul_underflow still propagates for stage 3 to handle.
- Integer multiplies are unaffected either way.

## Test plan
- Reset: hold reset 2 cycles with valid inputs present -> fx2_instruction_valid=0 and all fx2 data outputs 0.
- Alignment: se=0x00C00001, s=3 -> se_out=0x00180000, guard=0, round=0, sticky=1. Same se, s=0 -> unchanged with G/R/S=0. s=32 -> 0.
- Signed multiply: OP_MULH_I, 0xFFFFFFFF x 0x00000002 -> product 0xFFFFFFFFFFFFFFFE. OP_MULH_U with the same operands -> 0x00000001FFFFFFFE.
- fmul: multiplicand=multiplier=0x00800000 -> product 0x0000400000000000; exponent and sign passed through.
- Rollback: valid instruction on thread 2 with wb_rollback_en=1, thread 2 -> valid 0 next cycle. Rollback of thread 1 instead -> valid 1.
- Flush macro: OP_MUL_F with fx1_mul_underflow=1 and product nonzero -> with FX2_MUL_UNDERFLOW_FLUSH_EN, product=0 and exponent=0. Without it, raw product, exponent and underflow flag are seen.
